// File: rtl/bist_pkg.sv
// BIST shared types and constants: FSM states, widths, LFSR/MISR taps.
// No ports; imported by bist_misr and bist_controller.
package bist_pkg;

  localparam int PAT_W  = 9;
  localparam int RESP_W = 2;
  localparam int MISR_W = 16;
  localparam int CNT_W  = 16;

  // Taps in 1-based polynomial notation.
  localparam int LFSR_TAP_A = 9;
  localparam int LFSR_TAP_B = 5;
  localparam int MISR_TAP_A = 16;
  localparam int MISR_TAP_B = 14;
  localparam int MISR_TAP_C = 13;
  localparam int MISR_TAP_D = 11;

  typedef enum logic [2:0] {
    IDLE,
    SEED,
    APPLY,
    CAPTURE,
    DONE
  } state_t;

  function automatic logic [PAT_W-1:0] lfsr_step(
    input logic [PAT_W-1:0] l
  );
    return {l[PAT_W-2:0],
            l[LFSR_TAP_A-1] ^ l[LFSR_TAP_B-1]};
  endfunction

endpackage

// File: rtl/bist_misr.sv
// Multiple-input signature register compacting CUT responses.
// Ports: clk, rst, clr (zero sig), en (compact din), din, sig.
import bist_pkg::*;

module bist_misr (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [RESP_W-1:0] din,
  output logic [MISR_W-1:0] sig
);

  logic fb;

  assign fb = sig[MISR_TAP_A-1] ^ sig[MISR_TAP_B-1]
            ^ sig[MISR_TAP_C-1] ^ sig[MISR_TAP_D-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig <= '0;
    end else if (clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= {sig[MISR_W-2:0], fb}
           ^ {{(MISR_W-RESP_W){1'b0}}, din};
    end
  end

endmodule

// File: rtl/bist_controller.sv
// BIST sequencer: LFSR patterns to the CUT, MISR compaction, pass/fail.
// Ports: start/abort/seed/num_patterns/golden_sig in; cut_in/cut_out to CUT;
// busy/done/pass/signature/pat_count status out.
import bist_pkg::*;

module bist_controller (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [PAT_W-1:0]  seed,
  input  logic [CNT_W-1:0]  num_patterns,
  input  logic [MISR_W-1:0] golden_sig,
  output logic [PAT_W-1:0]  cut_in,
  input  logic [RESP_W-1:0] cut_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [MISR_W-1:0] signature,
  output logic [CNT_W-1:0]  pat_count
);

  state_t            state;
  state_t            state_nxt;
  logic              accept;
  logic              capture;
  logic [PAT_W-1:0]  lfsr;
  logic [PAT_W-1:0]  seed_q;
  logic [CNT_W-1:0]  num_q;
  logic [MISR_W-1:0] gold_q;
  logic [CNT_W-1:0]  cnt_inc;

  assign cnt_inc = pat_count + 1'b1;
  assign capture = (state == CAPTURE) && !abort;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state_nxt = SEED;
            accept    = 1'b1;
          end
        end
        SEED:    state_nxt = (num_q == '0) ? DONE : APPLY;
        APPLY:   state_nxt = CAPTURE;
        CAPTURE: state_nxt = (cnt_inc == num_q) ? DONE : APPLY;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lfsr      <= PAT_W'(1);
      cut_in    <= '0;
      pat_count <= '0;
      seed_q    <= '0;
      num_q     <= '0;
      gold_q    <= '0;
    end else begin
      state <= state_nxt;
      if (abort) begin
        cut_in <= '0;
      end else begin
        if (accept) begin
          seed_q    <= seed;
          num_q     <= num_patterns;
          gold_q    <= golden_sig;
          pat_count <= '0;
        end
        if (state == SEED) begin
          // all-zero is the LFSR lock-up state
          lfsr <= (seed_q == '0) ? PAT_W'(1) : seed_q;
        end
        if (state == APPLY) begin
          cut_in <= lfsr;
        end
        if (state == CAPTURE) begin
          lfsr      <= lfsr_step(lfsr);
          pat_count <= cnt_inc;
        end
      end
    end
  end

  bist_misr u_misr (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .en  (capture),
    .din (cut_out),
    .sig (signature)
  );

  // Decoded from registers only; cut_out never reaches an output directly.
  assign busy = (state == SEED) || (state == APPLY)
             || (state == CAPTURE);
  assign done = (state == DONE);
  assign pass = done && (signature == gold_q);

endmodule

// File: tb/tb_bist_controller.sv
// Directed bench for bist_controller with a pattern scoreboard
// and an independent LFSR/MISR reference model.
module tb_bist_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [8:0]  seed;
  logic [15:0] num_patterns;
  logic [15:0] golden_sig;
  logic [8:0]  cut_in;
  logic [1:0]  cut_out;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] signature;
  logic [15:0] pat_count;

  int n_cmp = 0;
  int n_bad = 0;
  int mode  = 0;
  logic [8:0] exp_q[$];
  logic [15:0] ref_sig;

  bist_controller dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .seed         (seed),
    .num_patterns (num_patterns),
    .golden_sig   (golden_sig),
    .cut_in       (cut_in),
    .cut_out      (cut_out),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .signature    (signature),
    .pat_count    (pat_count)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] resp(input logic [8:0] p);
    case (mode)
      1:       return 2'b01;
      2:       return p[1:0] ^ p[8:7];
      default: return 2'b00;
    endcase
  endfunction

  // CUT stand-in
  always_comb begin
    cut_out = 2'b00;
    cut_out = resp(cut_in);
  end

  function automatic logic [15:0] m_step(input logic [15:0] m,
                                         input logic [1:0] r);
    logic fb;
    fb = ^(m & 16'hB400);
    return {m[14:0], fb} ^ {14'd0, r};
  endfunction

  function automatic logic [8:0] l_step(input logic [8:0] l);
    return {l[7:0], ^(l & 9'h110)};
  endfunction

  function automatic logic [15:0] model_sig(input logic [8:0] s,
                                            input int n);
    logic [8:0]  l;
    logic [15:0] m;
    l = (s == 9'd0) ? 9'd1 : s;
    m = 16'd0;
    for (int i = 0; i < n; i++) begin
      m = m_step(m, resp(l));
      l = l_step(l);
    end
    return m;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [8:0] s, input int n,
                     input logic [15:0] g);
    logic [8:0]  l;
    logic [15:0] m;
    l = (s == 9'd0) ? 9'd1 : s;
    m = 16'd0;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(l);
      m = m_step(m, resp(l));
      l = l_step(l);
    end
    seed = s;
    num_patterns = 16'(n);
    golden_sig = g;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_seed", busy, 1);
    check("done_start", done, 0);
    for (int e = 2; e <= 2 * n + 2; e++) begin
      tick();
      if (e % 2 == 1) check("cut_in", cut_in, exp_q.pop_front());
      if (e == 2 * n + 1) check("done_early", done, 0);
    end
    check("done", done, 1);
    check("busy_done", busy, 0);
    check("pat_count", pat_count, n);
    check("signature", signature, m);
    check("pass", pass, (m == g));
    check("q_empty", exp_q.size(), 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    seed = '0;
    num_patterns = '0;
    golden_sig = '0;
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_cut_in", cut_in, 0);
    check("rst_sig", signature, 0);
    check("rst_cnt", pat_count, 0);
    rst = 1'b0;
    tick();

    // asynchronous reset in the middle of the second CAPTURE
    mode = 1;
    seed = 9'h001;
    num_patterns = 16'd6;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("pre_rst_cnt", pat_count, 1);
    check("pre_rst_sig", signature, m_step(16'd0, 2'b01));
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_cut_in", cut_in, 0);
    check("arst_sig", signature, 0);
    check("arst_cnt", pat_count, 0);
    rst = 1'b0;
    tick();
    check("arst_idle", busy, 0);

    // tied 00: all-zero signature, golden 0 passes
    mode = 0;
    run(9'h001, 6, 16'h0000);
    check("sig_zero", signature, 0);
    check("pass_zero", pass, 1);

    // tied 01: nonzero signature, golden 0 fails
    mode = 1;
    run(9'h001, 6, 16'h0000);
    check("sig_nonzero", (signature != 16'd0), 1);
    check("fail_01", pass, 0);

    // response-dependent CUT, correct golden programmed
    mode = 2;
    ref_sig = model_sig(9'h0A5, 20);
    run(9'h0A5, 20, ref_sig);

    // zero seed is replaced by 1
    mode = 0;
    run(9'h000, 1, 16'h0000);
    check("zero_seed_cut", cut_in, 9'h001);

    // zero patterns after a nonzero signature
    mode = 1;
    run(9'h003, 3, 16'h0000);
    run(9'h011, 0, 16'h0000);

    // abort priority over start in DONE
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("abort_start_done", done, 0);
    check("abort_start_busy", busy, 0);

    // abort on the 3rd APPLY, ignored start while busy
    mode = 2;
    ref_sig = model_sig(9'h05A, 2);
    seed = 9'h05A;
    num_patterns = 16'd10;
    golden_sig = 16'h0000;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    seed = 9'h1FF;
    num_patterns = 16'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_start_ign", pat_count, 1);
    check("busy_still", busy, 1);
    tick();
    tick();
    abort = 1'b1;
    tick();
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_pass", pass, 0);
    check("abort_cnt", pat_count, 2);
    check("abort_sig", signature, ref_sig);
    check("abort_cut_in", cut_in, 0);
    abort = 1'b0;
    tick();
    check("abort_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bist_controller.md
Name: bist_controller

Overview:
- Built-in self-test sequencer for the combinational fault-simulation test circuits (9 primary inputs, 2 primary outputs).
- Generates pseudo-random patterns with an LFSR and drives them onto the circuit inputs. Captures the circuit outputs one cycle later and compacts them into a MISR signature.
- Reports pass/fail against a programmed golden signature.
- Sits between the testbench/host and the circuit under test (CUT). Its signature equals the one the parallel fault simulator computes for the fault-free machine.

Parameters:
- PAT_W, 9: CUT input width. Packing is {a[3:0], b, c, d[2:0]}, MSB first.
- RESP_W, 2: CUT output width, packed {f[1], f[0]}.
- MISR_W, 16: signature width.
- CNT_W, 16: pattern counter width.

Ports:
- clk, in, 1: clock; all state updates on the rising edge.
- rst, in, 1: asynchronous, active-high reset.
- start, in, 1: one-cycle pulse; starts a run. Accepted only in IDLE or DONE.
- abort, in, 1: level; forces IDLE from any state.
- seed, in, PAT_W: LFSR seed, sampled on the accepted start.
- num_patterns, in, CNT_W: number of patterns to apply, sampled on the accepted start.
- golden_sig, in, MISR_W: expected signature, sampled on the accepted start.
- cut_in, out, PAT_W: pattern driven to the CUT.
- cut_out, in, RESP_W: CUT response.
- busy, out, 1: high in SEED, APPLY and CAPTURE.
- done, out, 1: high in DONE.
- pass, out, 1: valid while done is high; 1 when signature == golden.
- signature, out, MISR_W: current MISR value.
- pat_count, out, CNT_W: number of patterns captured so far.

Behaviour:
- Reset (asynchronous) drives:
  - state=IDLE;
  - cut_in, signature, pat_count = 0;
  - busy, done, pass = 0;
  - lfsr = 1.
- IDLE/DONE + start (abort low):
  - latch seed, num_patterns and golden_sig;
  - clear pat_count and the MISR to 0;
  - go to SEED.
- start while busy is ignored.
- SEED:
  - lfsr <= seed; a seed of 0 is replaced by 1 to avoid the LFSR lock-up state;
  - if num_patterns==0, go to DONE with signature=0;
  - otherwise go to APPLY.
- APPLY (1 cycle): cut_in <= lfsr; go to CAPTURE.
- CAPTURE (1 cycle), sampling cut_out (combinational settle time = 1 cycle):
  - misr <= {misr[14:0], fb} ^ {{MISR_W-RESP_W}'b0, cut_out}, where fb = misr[15]^misr[13]^misr[12]^misr[10];
  - lfsr <= {lfsr[7:0], lfsr[8]^lfsr[4]};
  - pat_count <= pat_count+1;
  - if pat_count+1 == num_patterns, go to DONE; else go to APPLY.
- Throughput: one pattern per 2 cycles. Start-to-done latency is 2+2*N cycles.
- DONE:
  - done=1, pass=(misr==golden_latched), held until the next start or abort;
  - cut_in holds the last pattern.
- abort:
  - takes priority over start and over every transition;
  - next state IDLE, with busy=0, done=0, pass=0;
  - signature and pat_count hold their partial values for debug;
  - cut_in returns to 0.
- Reset mid-run: immediate return to reset values, no completion reported.
- Counter wrap: num_patterns=2^CNT_W-1 is the maximum. pat_count never wraps within a run.
- LFSR period: 511 for the 9-bit polynomial. Patterns repeat beyond 511; this is permitted and not flagged.
- Outputs are registered. No combinational path from cut_out to any output.

Decomposition:
- Package bist_pkg:
  - state enum {IDLE, SEED, APPLY, CAPTURE, DONE};
  - LFSR tap constants (9,5) and MISR tap constants (16,14,13,11);
  - default widths.
- Sub-module bist_misr holds the signature register:
  - ports: clk, rst, clr, en, din[RESP_W], sig[MISR_W];
  - reusable by other CUT test designs.
- The LFSR stays inline.

Test Plan:
- rst pulse mid-CAPTURE -> all outputs 0 immediately (asynchronous), state IDLE; a following start runs normally.
- seed=9'h001, num_patterns=6, CUT outputs tied 2'b00:
  - cut_in sequence 001, 002, 004, 008, 010, 021;
  - done asserted at cycle 14 after start;
  - signature=0, pat_count=6;
  - golden=0 -> pass=1.
- Same run with cut_out tied 2'b01 and golden=0 -> signature != 0, pass=0. Compare against the bist_misr reference-model value.
- seed=0, num_patterns=1 -> cut_in=9'h001 applied (zero seed replaced).
- num_patterns=0 -> done at cycle 2 after start, signature=0, pat_count=0.
- abort asserted on the 3rd APPLY -> next cycle IDLE, busy=0, done=0, pat_count=2; start pulsed while busy before the abort is ignored.
